ps2_command_tx: RTL
===================

// Module: ps2_command_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: the send side of the keyboard link whose receive side
//  supplies ps2_key_data/ps2_key_pressed to the game logic. Sends one command byte
//  (e.g. 0xED set-LEDs, 0xFF reset) using the standard request-to-send sequence.
//  Drives the open-drain PS2_CLK/PS2_DAT lines through active-high pull-low enables and
//  reports the device acknowledge. Sits beside the PS/2 receiver at the top level.
// PARAMETERS
//  INHIBIT_CYCLES  6000    clocks PS2_CLK is held low before the start bit (120 us @ 50 MHz)
//  RTS_TIMEOUT     750000  max clocks from clock release to first device falling edge (15 ms)
//  XFER_TIMEOUT    100000  max clocks from first falling edge to ack sampled (2 ms)
// PORTS
//  clock        in   1  system clock
//  resetn       in   1  synchronous, active-low reset
//  send_data    in   8  command byte, sampled when send_req && !busy
//  send_req     in   1  one-cycle request to transmit send_data
//  ps2_clk_in   in   1  raw PS2_CLK pin value (asynchronous)
//  ps2_dat_in   in   1  raw PS2_DAT pin value (asynchronous)
//  ps2_clk_low  out  1  1 = drive PS2_CLK low; 0 = release (high-Z)
//  ps2_dat_low  out  1  1 = drive PS2_DAT low; 0 = release (high-Z)
//  busy         out  1  high from accepted request until the done/error pulse
//  send_done    out  1  one-cycle pulse: byte sent and device ack received
//  send_error   out  1  one-cycle pulse: timeout, or no ack (PS2_DAT high at ack edge)
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): all outputs 0, state IDLE, counters cleared, both lines released.
//    A reset mid-transfer releases both lines on the next edge; no done/error pulse is issued.
//  - ps2_clk_in/ps2_dat_in pass through a 2-flop synchroniser. A falling edge (fe) is
//    synchronised clk 1 -> 0, detected 3 cycles after the pin edge.
//  - Frame: shift = {stop=1, parity, send_data[7:0]}, sent LSB first.
//    parity = ~^send_data (odd parity).
//  - States:
//    IDLE:    send_req=1 -> latch frame, busy=1, ps2_clk_low=1, cnt=0 -> INHIBIT.
//             send_req while busy is ignored (not queued).
//    INHIBIT: cnt counts to INHIBIT_CYCLES-1, then ps2_dat_low=1 (start bit) -> START.
//    START:   one cycle, then ps2_clk_low=0, cnt=0, bitcnt=0 -> WAIT_DEV.
//    WAIT_DEV: on fe, drive bit 0 (ps2_dat_low = ~shift[0]), bitcnt=1, cnt=0 -> DATA.
//             cnt reaching RTS_TIMEOUT -> ERROR.
//    DATA:    on each fe, drive the next bit. Bits 1-7 are data, bitcnt 8 is parity,
//             bitcnt 9 is stop (ps2_dat_low=0).
//             On the fe after the stop bit (bitcnt==10): sample dat_sync ->
//             0 goes to WAIT_IDLE, 1 goes to ERROR.
//             cnt reaching XFER_TIMEOUT (counted since WAIT_DEV exit) -> ERROR.
//    WAIT_IDLE: wait until clk_sync=1 and dat_sync=1 -> DONE.
//             The XFER_TIMEOUT window still applies -> ERROR.
//    DONE:    send_done=1 for one cycle, busy=0 -> IDLE.
//    ERROR:   both lines released, send_error=1 for one cycle, busy=0 -> IDLE.
//  - Line changes are registered: each takes effect the cycle after the triggering fe.
//  - Counters: cnt is 20 bits and saturates; bitcnt is 4 bits.
//  - A new send_req is accepted in the cycle after DONE/ERROR (IDLE).
// TESTING (INHIBIT_CYCLES=8, RTS_TIMEOUT=200, XFER_TIMEOUT=2000; device model clocks at 40 cycles per half-period)
//  1. send 0xED, device acks -> ps2_clk_low high for 8 cycles; DAT bits on fe 1..10 are
//     1,0,1,1,0,1,1,1, parity 1, stop 1; send_done pulse once; busy falls on the same cycle.
//  2. send 0x07 -> parity bit 0; send 0x00 -> parity bit 1; both get send_done.
//  3. device never clocks after release -> send_error pulse at RTS_TIMEOUT, both lines released.
//  4. device holds DAT high at the ack edge -> send_error, no send_done.
//  5. send_req pulsed during busy with 0x55 -> ignored; frame still carries the first byte;
//     exactly one done pulse.
//  6. resetn low during the DATA state at bit 4 -> next cycle ps2_clk_low=0, ps2_dat_low=0,
//     busy=0, no pulses; a following send 0xFF completes normally.

Source files
------------

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-bit frame, and the
// device's acknowledge. It drives the open-drain lines through active-high pull-low enables.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int RTS_TIMEOUT    = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] send_data,
  input  logic       send_req,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_low,
  output logic       ps2_dat_low,
  output logic       busy,
  output logic       send_done,
  output logic       send_error
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, WAIT_DEV, DATA, WAIT_IDLE, DONE, ERROR
  } state_t;

  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] RTS_LIM  = 20'(RTS_TIMEOUT);
  localparam logic [19:0] XFER_LIM = 20'(XFER_TIMEOUT);

  state_t      state;
  logic [1:0]  clkSync, datSync;
  logic        clkPrev;
  logic        fe;
  logic [9:0]  shift;
  logic [19:0] cnt, cntInc;
  logic [3:0]  bitCnt;

  // Synchronisers idle high so that leaving reset cannot produce a false falling edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      clkSync <= 2'b11;
      datSync <= 2'b11;
      clkPrev <= 1'b1;
    end else begin
      clkSync <= {clkSync[0], ps2_clk_in};
      datSync <= {datSync[0], ps2_dat_in};
      clkPrev <= clkSync[1];
    end
  end

  assign fe     = clkPrev & ~clkSync[1];
  assign cntInc = (cnt == 20'hFFFFF) ? cnt : cnt + 20'd1;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      shift       <= '0;
      cnt         <= '0;
      bitCnt      <= '0;
      ps2_clk_low <= 1'b0;
      ps2_dat_low <= 1'b0;
      busy        <= 1'b0;
      send_done   <= 1'b0;
      send_error  <= 1'b0;
    end else begin
      send_done  <= 1'b0;
      send_error <= 1'b0;
      case (state)
        IDLE: if (send_req) begin
          shift       <= {1'b1, ~^send_data, send_data};
          busy        <= 1'b1;
          ps2_clk_low <= 1'b1;
          cnt         <= '0;
          state       <= INHIBIT;
        end
        INHIBIT: if (cnt == INH_LAST) begin
          ps2_dat_low <= 1'b1;
          state       <= START;
        end else begin
          cnt <= cntInc;
        end
        START: begin
          ps2_clk_low <= 1'b0;
          cnt         <= '0;
          bitCnt      <= '0;
          state       <= WAIT_DEV;
        end
        WAIT_DEV: if (fe) begin
          ps2_dat_low <= ~shift[0];
          shift       <= {1'b1, shift[9:1]};
          bitCnt      <= 4'd1;
          cnt         <= '0;
          state       <= DATA;
        end else if (cnt >= RTS_LIM) begin
          ps2_clk_low <= 1'b0;
          ps2_dat_low <= 1'b0;
          send_error  <= 1'b1;
          busy        <= 1'b0;
          state       <= ERROR;
        end else begin
          cnt <= cntInc;
        end
        DATA: begin
          cnt <= cntInc;
          if (cnt >= XFER_LIM || (fe && bitCnt == 4'd10 && datSync[1])) begin
            ps2_clk_low <= 1'b0;
            ps2_dat_low <= 1'b0;
            send_error  <= 1'b1;
            busy        <= 1'b0;
            state       <= ERROR;
          end else if (fe && bitCnt == 4'd10) begin
            state <= WAIT_IDLE;
          end else if (fe) begin
            // Shift refills with 1s, so the stop bit (and anything past it) releases DAT.
            ps2_dat_low <= ~shift[0];
            shift       <= {1'b1, shift[9:1]};
            bitCnt      <= bitCnt + 4'd1;
          end
        end
        WAIT_IDLE: begin
          cnt <= cntInc;
          if (cnt >= XFER_LIM) begin
            ps2_clk_low <= 1'b0;
            ps2_dat_low <= 1'b0;
            send_error  <= 1'b1;
            busy        <= 1'b0;
            state       <= ERROR;
          end else if (clkSync[1] && datSync[1]) begin
            send_done <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
